// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: widths, state encoding,
// and the PC wrap helper.
package fetch_ctrl_pkg;

   localparam int PC_W           = 32;
   localparam int INST_W         = 32;
   localparam int ENTRY_W        = PC_W + INST_W;
   localparam int IMEM_DEPTH_DEF = 128;

   typedef enum logic [1:0] {
      FC_IDLE  = 2'd0,
      FC_RUN   = 2'd1,
      FC_DRAIN = 2'd2
   } fc_state_e;

   function automatic logic [PC_W-1:0] pc_wrap(input logic [PC_W-1:0] pc, input int depth);
      return pc % PC_W'(depth);
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch control bus: sequencing controls, instruction memory port and decode handshake.
// master = fetch sequencer side, slave = surrounding core / memory side.
interface fetch_ctrl_if;
   import fetch_ctrl_pkg::*;

   logic              start;
   logic              halt_req;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic [PC_W-1:0]   imem_pc;
   logic [INST_W-1:0] imem_inst;
   logic              out_valid;
   logic              out_ready;
   logic [INST_W-1:0] out_inst;
   logic [PC_W-1:0]   out_pc;
   logic              busy;

   modport master (
      input  start, halt_req, redirect_valid, redirect_pc, imem_inst, out_ready,
      output imem_pc, out_valid, out_inst, out_pc, busy
   );

   modport slave (
      output start, halt_req, redirect_valid, redirect_pc, imem_inst, out_ready,
      input  imem_pc, out_valid, out_inst, out_pc, busy
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous fetch FIFO holding {pc, inst} entries. Flush wins over push/pop,
// and a push into a full FIFO is accepted when the head is popped in the same cycle.
module fetch_fifo #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the instruction memory and
// buffers {pc, inst} pairs for decode.
//
//   state    | meaning
//   FC_IDLE  | not fetching; waits for start
//   FC_RUN   | fetching one word per cycle while the buffer has room
//   FC_DRAIN | fetch stopped; buffered entries still handed to decode
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter int RESET_PC   = 0,
   parameter int BUF_DEPTH  = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_ctrl_if.master bus
);

   localparam int CW = $clog2(BUF_DEPTH + 1);

   fc_state_e         state_q;
   logic [PC_W-1:0]   pc_q;
   logic              busy_q;
   logic [PC_W-1:0]   pc_next_d;
   logic [PC_W-1:0]   redirect_pc_d;
   logic              pop, push, flush, drained;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [ENTRY_W-1:0] fifo_rd_data;

   assign pop   = bus.out_valid & bus.out_ready;
   assign flush = bus.redirect_valid & (state_q != FC_IDLE);
   assign push  = (state_q == FC_RUN) & ~bus.redirect_valid & ~bus.halt_req
                  & (~fifo_full | pop);
   // Buffer is empty once this cycle's pop (if any) has been taken.
   assign drained = fifo_empty | ((fifo_count == CW'(1)) & pop);

   assign pc_next_d     = (pc_q == PC_W'(IMEM_DEPTH - 1)) ? '0 : pc_q + PC_W'(1);
   assign redirect_pc_d = pc_wrap(bus.redirect_pc, IMEM_DEPTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FC_IDLE;
         pc_q    <= PC_W'(RESET_PC);
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            FC_IDLE: begin
               if (bus.start) begin
                  state_q <= FC_RUN;
                  pc_q    <= PC_W'(RESET_PC);
                  busy_q  <= 1'b1;
               end
            end
            FC_RUN: begin
               if (bus.redirect_valid) begin
                  pc_q <= redirect_pc_d;
                  if (bus.halt_req) begin
                     state_q <= FC_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else if (bus.halt_req) begin
                  state_q <= drained ? FC_IDLE : FC_DRAIN;
                  busy_q  <= ~drained;
               end else if (push) begin
                  pc_q <= pc_next_d;
               end
            end
            FC_DRAIN: begin
               if (bus.redirect_valid) begin
                  pc_q    <= redirect_pc_d;
                  state_q <= FC_IDLE;
                  busy_q  <= 1'b0;
               end else if (drained) begin
                  state_q <= FC_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= FC_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .wr_data ({pc_q, bus.imem_inst}),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign bus.imem_pc   = pc_q;
   assign bus.out_valid = ~fifo_empty;
   assign bus.out_pc    = fifo_rd_data[ENTRY_W-1:INST_W];
   assign bus.out_inst  = fifo_rd_data[INST_W-1:0];
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random control traffic, checked
// against a queue-based reference model through a decoupled scoreboard monitor.
module tb_fetch_ctrl;

   localparam int DEPTH = 128;
   localparam int BUF   = 2;

   typedef enum int {M_IDLE, M_RUN, M_DRAIN} mstate_e;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_ctrl_if bus();

   fetch_ctrl #(
      .IMEM_DEPTH (DEPTH),
      .RESET_PC   (0),
      .BUF_DEPTH  (BUF)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] mem [DEPTH];
   assign bus.imem_inst = mem[bus.imem_pc[6:0]];

   mstate_e     m_st;
   int          m_pc;
   int          m_occ;
   logic [63:0] sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_st  = M_IDLE;
      m_pc  = 0;
      m_occ = 0;
      sb.delete();
   endfunction

   // Applies the effect of the clock edge that just occurred, using the inputs
   // that were held during the preceding cycle.
   function automatic void model_edge();
      bit popped;
      if (!rst_n) return;
      popped = bus.out_ready && (m_occ > 0);
      case (m_st)
         M_IDLE: begin
            if (bus.start) begin
               m_st = M_RUN;
               m_pc = 0;
            end
         end
         M_RUN: begin
            if (bus.redirect_valid) begin
               m_occ = 0;
               sb.delete();
               m_pc = int'(bus.redirect_pc % 32'(DEPTH));
               if (bus.halt_req) m_st = M_IDLE;
            end else if (bus.halt_req) begin
               if (popped) m_occ--;
               m_st = (m_occ == 0) ? M_IDLE : M_DRAIN;
            end else begin
               bit room;
               room = (m_occ < BUF) || popped;
               if (popped) m_occ--;
               if (room) begin
                  sb.push_back({32'(m_pc), mem[m_pc]});
                  m_occ++;
                  m_pc = (m_pc + 1) % DEPTH;
               end
            end
         end
         default: begin
            if (bus.redirect_valid) begin
               m_occ = 0;
               sb.delete();
               m_pc = int'(bus.redirect_pc % 32'(DEPTH));
               m_st = M_IDLE;
            end else begin
               if (popped) m_occ--;
               if (m_occ == 0) m_st = M_IDLE;
            end
         end
      endcase
   endfunction

   // Scoreboard monitor: compares mid-cycle, pops an expectation on each handshake.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         check("imem_pc", bus.imem_pc, 64'(m_pc));
         check("busy", bus.busy, (m_st != M_IDLE));
         check("out_valid", bus.out_valid, (sb.size() != 0));
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_entry", bus.out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("out_pc", bus.out_pc, e[63:32]);
               check("out_inst", bus.out_inst, e[31:0]);
            end
         end else if (!bus.out_valid) begin
            check("idle_out_pc", {bus.out_pc, bus.out_inst}, 64'd0);
         end
      end
   end

   task automatic step(input bit s, input bit h, input bit r, input logic [31:0] rp, input bit rdy);
      @(posedge clk);
      #1;
      model_edge();
      bus.start          = s;
      bus.halt_req       = h;
      bus.redirect_valid = r;
      bus.redirect_pc    = rp;
      bus.out_ready      = rdy;
   endtask

   task automatic run(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 0, 0, 32'd0, rdy);
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_imem_pc", bus.imem_pc, 0);
      check("rst_out_pc", bus.out_pc, 0);
      model_reset();
      bus.start          = 1'b0;
      bus.halt_req       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.out_ready      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
      bus.start          = 1'b0;
      bus.halt_req       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.out_ready      = 1'b0;
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // sustained streaming from RESET_PC
      step(1, 0, 0, 32'd0, 1);
      run(8, 1);
      step(0, 1, 0, 32'd0, 1);
      run(3, 1);

      // back-pressure fills the buffer, PC stalls, then drains in order
      step(1, 0, 0, 32'd0, 0);
      run(5, 0);
      run(6, 1);
      step(0, 1, 0, 32'd0, 1);
      run(3, 1);

      // redirect mid-run
      step(1, 0, 0, 32'd0, 1);
      run(5, 1);
      step(0, 0, 1, 32'd20, 1);
      run(4, 1);

      // halt with two entries buffered, start ignored while draining
      run(3, 0);
      step(0, 1, 0, 32'd0, 0);
      step(1, 0, 0, 32'd0, 1);
      run(4, 1);

      // wrap-around and out-of-range redirect target
      step(1, 0, 0, 32'd0, 1);
      run(2, 1);
      step(0, 0, 1, 32'd126, 1);
      run(5, 1);
      step(0, 0, 1, 32'd200, 1);
      run(3, 1);
      step(0, 1, 1, 32'd9, 1);
      run(2, 1);

      // asynchronous reset with a full buffer
      step(1, 0, 0, 32'd0, 0);
      run(4, 0);
      async_reset();

      for (int c = 0; c < 3000; c++) begin
         bit s, h, r, rdy;
         logic [31:0] rp;
         s   = ($urandom_range(99) < 15);
         h   = ($urandom_range(99) < 5);
         r   = ($urandom_range(99) < 5);
         rdy = ($urandom_range(99) < 70);
         rp  = ($urandom_range(3) == 0) ? $urandom() : 32'($urandom_range(255));
         step(s, h, r, rp, rdy);
         if ($urandom_range(999) < 3) async_reset();
      end
      run(4, 1);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
